// File: rtl/gate_truth_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_sequencer
// Description : Exhaustive truth-table sequencer for one combinational gate.
//               Drives every input vector in ascending order, holds each for
//               a fixed settle time, samples the gate output against a
//               latched expected table and reports a mismatch mask and a
//               pass flag.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_sequencer #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(2**N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   fail_mask
);

    localparam int              c_numVec     = 2 ** N_IN;
    localparam logic [N_IN-1:0] c_lastVec    = N_IN'(c_numVec - 1);
    // Counter reload value; a zero settle time bypasses SETTLE entirely
    localparam logic [3:0]      c_settleLoad = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam bit              c_noSettle   = (SETTLE_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } stateT;

    stateT                 r_state;
    logic [N_IN-1:0]       r_vec;
    logic [3:0]            r_settleCnt;
    logic [c_numVec-1:0]   r_expReg;

    logic                  w_mismatch;
    logic [c_numVec-1:0]   w_nextMask;

    // The vector index is itself the registered drive to the gate inputs
    assign dut_in = r_vec;

    // Mask as it will look once the current vector's result is recorded
    always_comb begin
        w_mismatch        = dut_out ^ r_expReg[r_vec];
        w_nextMask        = fail_mask;
        w_nextMask[r_vec] = w_mismatch;
    end

    // Sequencer: walks all vectors, records mismatches and reports the verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_settleCnt <= 4'd0;
            r_expReg    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_mask   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_expReg    <= expected;
                        fail_mask   <= '0;
                        pass        <= 1'b0;
                        r_vec       <= '0;
                        busy        <= 1'b1;
                        r_settleCnt <= c_settleLoad;
                        r_state     <= c_noSettle ? SAMPLE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_settleCnt == 4'd0) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_settleCnt <= r_settleCnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    fail_mask <= w_nextMask;
                    if (r_vec == c_lastVec) begin
                        r_vec   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_nextMask == '0);
                        r_state <= DONE;
                    end else begin
                        r_vec       <= r_vec + N_IN'(1);
                        r_settleCnt <= c_settleLoad;
                        r_state     <= c_noSettle ? SAMPLE : SETTLE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_truth_sequencer
// Description : Directed self-checking bench for gate_truth_sequencer. One
//               instance uses default parameters against an OR gate model
//               (optionally stuck-at-0), a second uses SETTLE_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_truth_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] expected;

    logic       startA, startB;
    logic [1:0] dutInA, dutInB;
    logic       dutOutA, dutOutB;
    logic       busyA, busyB, doneA, doneB, passA, passB;
    logic [3:0] failMaskA, failMaskB;

    logic       modeStuck;
    logic       sel;

    int nTests = 0;
    int nFail  = 0;

    // Gate models: OR gate, optionally stuck-at-0 on instance A
    assign dutOutA = modeStuck ? 1'b0 : (dutInA[0] | dutInA[1]);
    assign dutOutB = dutInB[0] | dutInB[1];

    // Observed signals of the instance currently under test
    logic [1:0] obsDutIn;
    logic       obsBusy, obsDone, obsPass;
    logic [3:0] obsMask;
    assign obsDutIn = sel ? dutInB    : dutInA;
    assign obsBusy  = sel ? busyB     : busyA;
    assign obsDone  = sel ? doneB     : doneA;
    assign obsPass  = sel ? passB     : passA;
    assign obsMask  = sel ? failMaskB : failMaskA;

    gate_truth_sequencer #(.N_IN(2), .SETTLE_CYCLES(2)) u_dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (startA),
        .expected  (expected),
        .dut_in    (dutInA),
        .dut_out   (dutOutA),
        .busy      (busyA),
        .done      (doneA),
        .pass      (passA),
        .fail_mask (failMaskA)
    );

    gate_truth_sequencer #(.N_IN(2), .SETTLE_CYCLES(0)) u_dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (startB),
        .expected  (expected),
        .dut_in    (dutInB),
        .dut_out   (dutOutB),
        .busy      (busyB),
        .done      (doneB),
        .pass      (passB),
        .fail_mask (failMaskB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic setStart(input logic v);
        if (sel) startB = v;
        else     startA = v;
    endtask

    // One full run on the selected instance; checks every cycle from the
    // cycle after the start edge (k=0) through the done cycle
    task automatic runCheck(input logic [3:0] expIn, input logic [3:0] wantMask,
                            input logic wantPass, input bit disturb, input int settle);
        int per;
        int last;
        per  = settle + 1;
        last = 4 * per;
        expected = expIn;
        setStart(1'b1);
        @(posedge clk);
        @(negedge clk);
        setStart(1'b0);
        for (int k = 0; k <= last; k++) begin
            if (disturb && (k == 3 || k == 7)) begin
                setStart(1'b1);
                expected = 4'b0000;
            end else begin
                setStart(1'b0);
            end
            checkVal($sformatf("dut_in k=%0d", k), 32'(obsDutIn), (k < last) ? 32'(k / per) : 32'd0);
            checkVal($sformatf("busy k=%0d", k),   32'(obsBusy),  (k < last) ? 32'd1 : 32'd0);
            checkVal($sformatf("done k=%0d", k),   32'(obsDone),  (k == last) ? 32'd1 : 32'd0);
            if (k == 0) begin
                checkVal("mask cleared", 32'(obsMask), 32'd0);
                checkVal("pass cleared", 32'(obsPass), 32'd0);
            end
            if (k == last) begin
                checkVal("fail_mask", 32'(obsMask), 32'(wantMask));
                checkVal("pass",      32'(obsPass), 32'(wantPass));
            end else begin
                @(negedge clk);
            end
        end
        setStart(1'b0);
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        startA    = 1'b0;
        startB    = 1'b0;
        expected  = 4'b0000;
        modeStuck = 1'b0;
        sel       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkVal("rst dut_in",    32'(dutInA),    32'd0);
        checkVal("rst busy",      32'(busyA),     32'd0);
        checkVal("rst done",      32'(doneA),     32'd0);
        checkVal("rst pass",      32'(passA),     32'd0);
        checkVal("rst fail_mask", 32'(failMaskA), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Healthy OR gate
        runCheck(4'b1110, 4'b0000, 1'b1, 1'b0, 2);
        @(negedge clk);

        // Stuck-at-0 gate, results held afterwards
        modeStuck = 1'b1;
        runCheck(4'b1110, 4'b1110, 1'b0, 1'b0, 2);
        repeat (3) @(negedge clk);
        checkVal("held fail_mask", 32'(failMaskA), 32'hE);
        checkVal("held pass",      32'(passA),     32'd0);
        checkVal("idle busy",      32'(busyA),     32'd0);

        // OR gate against AND table; the start clears the held results
        modeStuck = 1'b0;
        runCheck(4'b1000, 4'b0110, 1'b0, 1'b0, 2);
        @(negedge clk);

        // Re-pulsed start and mid-run expected change are ignored
        runCheck(4'b1110, 4'b0000, 1'b1, 1'b1, 2);
        @(negedge clk);
        checkVal("no restart busy", 32'(busyA), 32'd0);

        // start held high: next run accepted on the IDLE cycle after DONE
        expected = 4'b1110;
        startA   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (12) @(negedge clk);
        checkVal("held-start done", 32'(doneA), 32'd1);
        @(negedge clk);
        checkVal("held-start idle busy", 32'(busyA), 32'd0);
        @(negedge clk);
        checkVal("held-start rerun busy", 32'(busyA), 32'd1);
        startA = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (doneA) seen = 1'b1;
        end
        checkVal("held-start rerun done seen", 32'(seen), 32'd1);
        checkVal("held-start rerun pass", 32'(passA), 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-run (vector 2, SETTLE)
        expected = 4'b1110;
        startA   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startA = 1'b0;
        repeat (6) @(negedge clk);
        checkVal("pre-rst dut_in", 32'(dutInA), 32'd2);
        checkVal("pre-rst busy",   32'(busyA),  32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkVal("async dut_in",    32'(dutInA),    32'd0);
        checkVal("async busy",      32'(busyA),     32'd0);
        checkVal("async done",      32'(doneA),     32'd0);
        checkVal("async pass",      32'(passA),     32'd0);
        checkVal("async fail_mask", 32'(failMaskA), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (doneA || busyA) seen = 1'b1;
        end
        checkVal("no done after rst", 32'(seen), 32'd0);
        runCheck(4'b1110, 4'b0000, 1'b1, 1'b0, 2);
        @(negedge clk);

        // Zero settle time instance
        sel = 1'b1;
        runCheck(4'b1110, 4'b0000, 1'b1, 1'b0, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
